param_tensor_stream_source: RTL and testbench

//  Parametrised successor to the per-parameter bias/weight sources: streams a stored tensor from an

---
 rtl/param_tensor_stream_source.sv | 171 +++++++++++++++++
 tb/tb_param_tensor_stream_source.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_tensor_stream_source.sv
// Streams a stored tensor from a registered parameter ROM onto a valid/ready bus, REPEAT passes per start.
// Optional feature macro: PARAM_SOURCE_LAST_EN adds data_out_last (end-of-pass flag).
module param_tensor_stream_source #(
  parameter int DATA_PRECISION_0  = 16,
  parameter int TENSOR_SIZE_DIM_0 = 32,
  parameter int TENSOR_SIZE_DIM_1 = 1,
  parameter int PARALLELISM_DIM_0 = 4,
  parameter int PARALLELISM_DIM_1 = 1,
  parameter int REPEAT            = 1,
  parameter int CONTINUOUS        = 0,
  parameter int ROM_LATENCY       = 2,
  parameter int FIFO_DEPTH        = ROM_LATENCY + 2,
  localparam int NPAR  = PARALLELISM_DIM_0 * PARALLELISM_DIM_1,
  localparam int DEPTH = (TENSOR_SIZE_DIM_0 / PARALLELISM_DIM_0) * (TENSOR_SIZE_DIM_1 / PARALLELISM_DIM_1),
  localparam int W     = NPAR * DATA_PRECISION_0,
  localparam int AW    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic [AW-1:0]               rom_addr,
  output logic                        rom_ce,
  input  logic [W-1:0]                rom_q,
  output logic [DATA_PRECISION_0-1:0] data_out [NPAR],
  output logic                        data_out_valid,
`ifdef PARAM_SOURCE_LAST_EN
  output logic                        data_out_last,
`endif
  input  logic                        data_out_ready
);
  // Handshake: a beat transfers on a rising clk edge with data_out_valid && data_out_ready;
  // while valid is high and ready low, data_out (and data_out_last) hold their value.

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int RW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [RW-1:0]     pass_q, pass_d;
  logic [ROM_LATENCY-1:0] tag_q, tag_d;
  logic [W-1:0]      fifo_mem_q [FIFO_DEPTH];
  logic [W-1:0]      fifo_mem_d [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     fifo_count_q, fifo_count_d;
  logic              issue, last_fetch, addr_at_end, pass_at_end;
  logic              fifo_push, fifo_pop, head_valid;
  int                in_flight;
`ifdef PARAM_SOURCE_LAST_EN
  logic [ROM_LATENCY-1:0] tag_last_q, tag_last_d;
  logic              fifo_last_q [FIFO_DEPTH];
  logic              fifo_last_d [FIFO_DEPTH];
`endif

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Fetch credit counts in-flight reads so every returning ROM word has a FIFO slot.
  always_comb begin
    in_flight = 0;
    for (int i = 0; i < ROM_LATENCY; i++) in_flight = in_flight + int'(tag_q[i]);
    head_valid  = (fifo_count_q != '0);
    issue       = (state_q == S_RUN) && ((int'(fifo_count_q) + in_flight) < FIFO_DEPTH);
    addr_at_end = (addr_q == AW'(DEPTH - 1));
    pass_at_end = (pass_q == RW'(REPEAT - 1));
    last_fetch  = issue && addr_at_end && pass_at_end && (CONTINUOUS == 0);
    fifo_push   = tag_q[ROM_LATENCY-1];
    fifo_pop    = head_valid && data_out_ready;

    addr_d = addr_q;
    pass_d = pass_q;
    if (issue) begin
      addr_d = addr_at_end ? '0 : addr_q + 1'b1;
      if (addr_at_end) pass_d = pass_at_end ? '0 : pass_q + 1'b1;
    end

    tag_d[0] = issue;
    for (int i = 1; i < ROM_LATENCY; i++) tag_d[i] = tag_q[i-1];

    fifo_mem_d = fifo_mem_q;
    if (fifo_push) fifo_mem_d[wr_ptr_q] = rom_q;
    wr_ptr_d = fifo_push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = fifo_pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fifo_count_d = fifo_count_q;
    if (fifo_push && !fifo_pop)      fifo_count_d = fifo_count_q + CW'(1);
    else if (!fifo_push && fifo_pop) fifo_count_d = fifo_count_q - CW'(1);

`ifdef PARAM_SOURCE_LAST_EN
    tag_last_d[0] = issue && addr_at_end;
    for (int i = 1; i < ROM_LATENCY; i++) tag_last_d[i] = tag_last_q[i-1];
    fifo_last_d = fifo_last_q;
    if (fifo_push) fifo_last_d[wr_ptr_q] = tag_last_q[ROM_LATENCY-1];
`endif
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM: next state; DRAIN leaves as soon as the final beat is handshaken
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (last_fetch) state_d = S_DRAIN;
      S_DRAIN: if ((fifo_count_d == '0) && (tag_d == '0)) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy     = (state_q != S_IDLE);
    rom_ce   = 1'b1;
    rom_addr = addr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q       <= '0;
      pass_q       <= '0;
      tag_q        <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
    end else begin
      addr_q       <= addr_d;
      pass_q       <= pass_d;
      tag_q        <= tag_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
    end
  end

  // Payload storage needs no reset: outputs are gated by head_valid.
  always_ff @(posedge clk) begin
    fifo_mem_q <= fifo_mem_d;
  end

  always_comb begin
    data_out_valid = head_valid;
    for (int j = 0; j < NPAR; j++)
      data_out[j] = head_valid ? fifo_mem_q[rd_ptr_q][DATA_PRECISION_0*j +: DATA_PRECISION_0] : '0;
  end

`ifdef PARAM_SOURCE_LAST_EN
  always_ff @(posedge clk) begin
    if (!rst) tag_last_q <= '0;
    else      tag_last_q <= tag_last_d;
  end

  always_ff @(posedge clk) begin
    fifo_last_q <= fifo_last_d;
  end

  always_comb begin
    data_out_last = head_valid ? fifo_last_q[rd_ptr_q] : 1'b0;
  end
`endif

  fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_push && !fifo_pop && (fifo_count_q == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_param_tensor_stream_source.sv
// Bench for param_tensor_stream_source: three instances (one-shot, REPEAT=3, continuous REPEAT=2)
// checked every cycle against a beat-index model; define PARAM_SOURCE_LAST_EN to also check data_out_last.
module tb_param_tensor_stream_source;
  localparam int PREC  = 16;
  localparam int NPAR  = 4;
  localparam int DEPTH = 8;
  localparam int W     = 64;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int NI    = 3;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b0;

  logic            start    [NI];
  logic            ready    [NI] = '{1'b1, 1'b1, 1'b1};
  logic            busy     [NI];
  logic            valid    [NI];
  logic            rom_ce   [NI];
  logic [AW-1:0]   rom_addr [NI];
  logic [AW-1:0]   rom_a1   [NI];
  logic [W-1:0]    rom_q    [NI];
  logic [PREC-1:0] dout0 [NPAR];
  logic [PREC-1:0] dout1 [NPAR];
  logic [PREC-1:0] dout2 [NPAR];
  logic [W-1:0]    dout_w [NI];
`ifdef PARAM_SOURCE_LAST_EN
  logic            last [NI];
`endif
  logic            rand_en [NI];
  logic            chk_en = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // model state
  logic         m_busy     [NI];
  int           m_n        [NI];
  int           m_left     [NI];
  int           since      [NI];
  logic         hold_ready [NI];
  logic         stall_prev [NI];
  logic [W-1:0] stall_data [NI];
  int           hs_cnt     [NI];
  logic [W-1:0] cap        [NI][32];

  param_tensor_stream_source dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .busy(busy[0]),
    .rom_addr(rom_addr[0]), .rom_ce(rom_ce[0]), .rom_q(rom_q[0]),
    .data_out(dout0), .data_out_valid(valid[0]),
`ifdef PARAM_SOURCE_LAST_EN
    .data_out_last(last[0]),
`endif
    .data_out_ready(ready[0])
  );

  param_tensor_stream_source #(.REPEAT(3)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .busy(busy[1]),
    .rom_addr(rom_addr[1]), .rom_ce(rom_ce[1]), .rom_q(rom_q[1]),
    .data_out(dout1), .data_out_valid(valid[1]),
`ifdef PARAM_SOURCE_LAST_EN
    .data_out_last(last[1]),
`endif
    .data_out_ready(ready[1])
  );

  param_tensor_stream_source #(.REPEAT(2), .CONTINUOUS(1)) dut2 (
    .clk(clk), .rst(rst), .start(start[2]), .busy(busy[2]),
    .rom_addr(rom_addr[2]), .rom_ce(rom_ce[2]), .rom_q(rom_q[2]),
    .data_out(dout2), .data_out_valid(valid[2]),
`ifdef PARAM_SOURCE_LAST_EN
    .data_out_last(last[2]),
`endif
    .data_out_ready(ready[2])
  );

  function automatic int rep_of(input int i);
    return (i == 1) ? 3 : ((i == 2) ? 2 : 1);
  endfunction

  function automatic bit cont_of(input int i);
    return (i == 2);
  endfunction

  // ROM word k of instance inst: element j = inst*0x1000 + k*0x10 + j
  function automatic logic [W-1:0] word_of(input int inst, input int k);
    logic [W-1:0] w;
    for (int j = 0; j < NPAR; j++) w[j*PREC +: PREC] = PREC'(inst*4096 + k*16 + j);
    return w;
  endfunction

  // two-cycle registered ROMs
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      rom_a1[i] <= rom_addr[i];
      rom_q[i]  <= word_of(i, int'(rom_a1[i]));
    end
  end

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < NI; i++) ready[i] = rand_en[i] ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always_comb begin
    for (int i = 0; i < NI; i++) dout_w[i] = '0;
    for (int j = 0; j < NPAR; j++) begin
      dout_w[0][j*PREC +: PREC] = dout0[j];
      dout_w[1][j*PREC +: PREC] = dout1[j];
      dout_w[2][j*PREC +: PREC] = dout2[j];
    end
  end

  task automatic check(input string name, input int inst, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s inst%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  // scoreboard: expected beat n after a start is ROM word n mod DEPTH; DEPTH*REPEAT beats per start
  always @(negedge clk) begin : cmp
    logic was_busy;
    if (chk_en) begin
      for (int i = 0; i < NI; i++) begin
        was_busy = m_busy[i];
        if (was_busy) since[i]++;
        check("busy", i, W'(busy[i]), W'(was_busy));
        if (!was_busy)                              check("idle_valid", i, W'(valid[i]), '0);
        else if (since[i] <= LAT)                   check("early_valid", i, W'(valid[i]), '0);
        else if (since[i] == LAT + 1 || hold_ready[i]) check("stream_valid", i, W'(valid[i]), W'(1));
        if (stall_prev[i]) begin
          check("stall_valid", i, W'(valid[i]), W'(1));
          check("stall_data", i, dout_w[i], stall_data[i]);
        end
        if (!rst) begin
          m_busy[i]     = 1'b0;
          stall_prev[i] = 1'b0;
          since[i]      = 0;
        end else begin
          if (valid[i] && ready[i]) begin
            hs_cnt[i]++;
            if (was_busy) begin
              if (m_n[i] < 32) cap[i][m_n[i]] = dout_w[i];
              check("beat_data", i, dout_w[i], word_of(i, m_n[i] % DEPTH));
`ifdef PARAM_SOURCE_LAST_EN
              check("beat_last", i, W'(last[i]), W'((m_n[i] % DEPTH) == DEPTH - 1));
`endif
              m_n[i]++;
              if (!cont_of(i)) begin
                m_left[i]--;
                if (m_left[i] == 0) m_busy[i] = 1'b0;
              end
            end
          end
          if (!ready[i]) hold_ready[i] = 1'b0;
          stall_prev[i] = valid[i] && !ready[i];
          stall_data[i] = dout_w[i];
          if (start[i] && !was_busy) begin
            m_busy[i]     = 1'b1;
            m_n[i]        = 0;
            m_left[i]     = rep_of(i) * DEPTH;
            since[i]      = -1;
            hold_ready[i] = 1'b1;
          end
        end
      end
    end
  end

  // driver tasks
  task automatic pulse_start(input int i);
    @(posedge clk);
    #1 start[i] = 1'b1;
    @(posedge clk);
    #1 start[i] = 1'b0;
  endtask

  task automatic wait_idle(input int i, input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy[i] && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy[i]) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout inst%0d: busy still 1 after %0d cycles, required 0", i, budget);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got time %0t required under 200000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int n;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; rand_en[i] = 1'b0; m_busy[i] = 1'b0; m_n[i] = 0; m_left[i] = 0;
      since[i] = 0; hold_ready[i] = 1'b0; stall_prev[i] = 1'b0; stall_data[i] = '0; hs_cnt[i] = 0;
    end
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      check("rst_busy", i, W'(busy[i]), '0);
      check("rst_valid", i, W'(valid[i]), '0);
      check("rst_data", i, dout_w[i], '0);
      check("rst_addr", i, W'(rom_addr[i]), '0);
      check("rom_ce", i, W'(rom_ce[i]), W'(1));
    end

    // one-shot, REPEAT=3 and continuous streams with ready held high
    @(posedge clk);
    #1 for (int i = 0; i < NI; i++) start[i] = 1'b1;
    @(posedge clk);
    #1 for (int i = 0; i < NI; i++) start[i] = 1'b0;
    wait_idle(0, 60);
    check("t1_beats", 0, W'(hs_cnt[0]), W'(8));
    check("t1_first", 0, cap[0][0], 64'h0003_0002_0001_0000);
    check("t1_beat7", 0, cap[0][7], 64'h0073_0072_0071_0070);
    pulse_start(1);
    pulse_start(2);
    wait_idle(1, 80);
    check("t2_beats", 1, W'(hs_cnt[1]), W'(24));
    check("t2_pass2", 1, cap[1][16], 64'h1003_1002_1001_1000);
    check("t2_beat23", 1, cap[1][23], 64'h1073_1072_1071_1070);
    check("t4_busy", 2, W'(busy[2]), W'(1));
    check("t4_wrap", 2, cap[2][8], 64'h2003_2002_2001_2000);
    check("t4_beat15", 2, cap[2][15], 64'h2073_2072_2071_2070);

    // random backpressure with ignored mid-stream starts
    rand_en[0] = 1'b1;
    rand_en[2] = 1'b1;
    for (int r = 0; r < 4; r++) begin
      base = hs_cnt[0];
      pulse_start(0);
      repeat (4) @(posedge clk);
      pulse_start(0);
      pulse_start(2);
      wait_idle(0, 300);
      check("t3_beats", 0, W'(hs_cnt[0] - base), W'(8));
    end

    // reset mid-stream, then replay from address 0
    rand_en[0] = 1'b0;
    rand_en[2] = 1'b0;
    repeat (2) @(posedge clk);
    base = hs_cnt[0];
    pulse_start(0);
    n = 0;
    while ((hs_cnt[0] - base) < 4 && n < 50) begin
      @(posedge clk);
      n++;
    end
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("t5_valid", 0, W'(valid[0]), '0);
    check("t5_busy", 0, W'(busy[0]), '0);
    check("t5_data", 0, dout_w[0], '0);
    check("t5_count", 0, W'(hs_cnt[0] - base), W'(4));
    base = hs_cnt[0];
    pulse_start(0);
    pulse_start(2);
    wait_idle(0, 60);
    check("t5_replay", 0, W'(hs_cnt[0] - base), W'(8));
    check("t5_beat4", 0, cap[0][4], 64'h0043_0042_0041_0040);
    repeat (20) @(posedge clk);
    check("t4_restart_busy", 2, W'(busy[2]), W'(1));

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
